// File: rtl/serial_accumulator_calculator.sv
// Serial accumulator calculator: a WIDTH-bit accumulator that supports ADD, SUB,
// LOAD and CLEAR with an operand from the switches. ADD and SUB go through a
// single full-adder slice, one bit per clock. The accumulator and carry drive a
// bank of active-low seven-segment displays.
//
// Ports:
//   i_clk       system clock
//   i_reset     synchronous, active-high reset
//   i_operand   operand B, sampled only when a start is accepted
//   i_op        00 ADD, 01 SUB, 10 LOAD, 11 CLEAR, sampled only when a start is accepted
//   i_start     level request; the block acts on its rising edge
//   o_acc       accumulator value
//   o_carry     carry out of the last ADD/SUB (for SUB, 1 = no borrow)
//   o_overflow  two's-complement overflow of the last ADD/SUB
//   o_busy      serial operation in progress
//   o_done      one-cycle pulse when an operation completes
//   o_hex       digit k at [7k+6:7k]; low digits show o_acc, top digit shows o_carry

// Hex nibble to active-low seven-segment pattern (bit 0 = segment a).
// Ports: digit (4-bit value), segments (active-low, {g,f,e,d,c,b,a}).
module decoder_de10_lite (
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'b1111111;
    case (digit)
      4'h0: segments = 7'b1000000;
      4'h1: segments = 7'b1111001;
      4'h2: segments = 7'b0100100;
      4'h3: segments = 7'b0110000;
      4'h4: segments = 7'b0011001;
      4'h5: segments = 7'b0010010;
      4'h6: segments = 7'b0000010;
      4'h7: segments = 7'b1111000;
      4'h8: segments = 7'b0000000;
      4'h9: segments = 7'b0010000;
      4'hA: segments = 7'b0001000;
      4'hB: segments = 7'b0000011;
      4'hC: segments = 7'b1000110;
      4'hD: segments = 7'b0100001;
      4'hE: segments = 7'b0000110;
      4'hF: segments = 7'b0001110;
      default: segments = 7'b1111111;
    endcase
  end

endmodule

module serial_accumulator_calculator #(
  parameter  int unsigned WIDTH    = 8,
  localparam int unsigned N_DIGITS = WIDTH / 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [WIDTH-1:0]            i_operand,
  input  logic [1:0]                  i_op,
  input  logic                        i_start,
  output logic [WIDTH-1:0]            o_acc,
  output logic                        o_carry,
  output logic                        o_overflow,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [7*(N_DIGITS+1)-1:0]   o_hex
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t             state;
  logic               start_q;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               c_q;
  logic [CNT_W-1:0]   cnt;

  logic               start_edge;
  logic               sum_bit;
  logic               carry_next;

  // Rising edge of the start request
  assign start_edge = i_start & ~start_q;

  // Single full-adder slice on the LSBs of the operand shift registers
  assign sum_bit    = a_sr[0] ^ b_sr[0] ^ c_q;
  assign carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_q) | (b_sr[0] & c_q);

  // Control FSM, serial datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      start_q    <= 1'b1;  // a start held across reset must not trigger
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      c_q        <= 1'b0;
      cnt        <= '0;
      o_acc      <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      start_q <= i_start;
      o_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            case (i_op)
              OP_ADD, OP_SUB: begin
                // SUB is A + ~B + 1: invert B and seed the carry with 1
                a_sr   <= o_acc;
                b_sr   <= i_op[0] ? ~i_operand : i_operand;
                c_q    <= i_op[0];
                cnt    <= '0;
                o_busy <= 1'b1;
                state  <= CALC;
              end
              OP_LOAD: begin
                o_acc      <= i_operand;
                o_carry    <= 1'b0;
                o_overflow <= 1'b0;
                o_done     <= 1'b1;
              end
              default: begin
                o_acc      <= '0;
                o_carry    <= 1'b0;
                o_overflow <= 1'b0;
                o_done     <= 1'b1;
              end
            endcase
          end
        end
        CALC: begin
          c_q    <= carry_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // Last bit: a_sr[0]/b_sr[0] now hold the original operand MSBs
            o_acc      <= {sum_bit, res_sr[WIDTH-1:1]};
            o_carry    <= carry_next;
            o_overflow <= (a_sr[0] == b_sr[0]) & (sum_bit != a_sr[0]);
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display: accumulator nibbles LSB first, carry on the top digit
  for (genvar k = 0; k < int'(N_DIGITS); k++) begin : g_digit
    decoder_de10_lite u_dec (
      .digit    (o_acc[4*k +: 4]),
      .segments (o_hex[7*k +: 7])
    );
  end

  decoder_de10_lite u_dec_carry (
    .digit    ({3'b000, o_carry}),
    .segments (o_hex[7*N_DIGITS +: 7])
  );

endmodule

// File: tb/tb_serial_accumulator_calculator.sv
module tb_serial_accumulator_calculator;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] operand = '0;
  logic [1:0]   op = 2'b00;
  logic         start = 1'b0;
  logic [W-1:0] acc;
  logic         carry, ovf, busy, done;
  logic [20:0]  hex;

  logic [1:0]   op_s = 2'b00;
  logic         start_s = 1'b0;
  logic [3:0]   opnd4 = '0;
  logic [11:0]  opnd12 = '0;
  logic [3:0]   acc4;
  logic [11:0]  acc12;
  logic         c4, v4, busy4, done4, c12, v12, busy12, done12;
  logic [13:0]  hex4;
  logic [34:0]  hex12;

  always #5 clk = ~clk;

  serial_accumulator_calculator #(.WIDTH(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_operand(operand), .i_op(op), .i_start(start),
    .o_acc(acc), .o_carry(carry), .o_overflow(ovf), .o_busy(busy), .o_done(done), .o_hex(hex));

  serial_accumulator_calculator #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_operand(opnd4), .i_op(op_s), .i_start(start_s),
    .o_acc(acc4), .o_carry(c4), .o_overflow(v4), .o_busy(busy4), .o_done(done4), .o_hex(hex4));

  serial_accumulator_calculator #(.WIDTH(12)) dut12 (
    .i_clk(clk), .i_reset(rst), .i_operand(opnd12), .i_op(op_s), .i_start(start_s),
    .o_acc(acc12), .o_carry(c12), .o_overflow(v12), .o_busy(busy12), .o_done(done12), .o_hex(hex12));

  typedef struct packed {
    logic [7:0] acc;
    logic       c;
    logic       v;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] opnd;
    logic [7:0] acc;
    logic       c;
    logic       v;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every o_done pops one expected result
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_without_request: acc=0x%0h at %0t", acc, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_acc", 64'(acc), 64'(e.acc));
        check("sb_carry", 64'(carry), 64'(e.c));
        check("sb_overflow", 64'(ovf), 64'(e.v));
        check("sb_hex", 64'(hex), 64'({seg7({3'b000, e.c}), seg7(e.acc[7:4]), seg7(e.acc[3:0])}));
      end
    end
  end

  // One operation on the 8-bit DUT: push expectation, pulse start, time busy/done
  task automatic do_op(input logic [1:0] op_v, input logic [7:0] opnd,
                       input logic [7:0] e_acc, input logic e_c, input logic e_v);
    exp_t e;
    int   n_busy, lat;
    bit   seen, held;
    logic [7:0] acc0;
    bit   serial;
    serial = (op_v == 2'b00) || (op_v == 2'b01);
    @(negedge clk);
    op = op_v; operand = opnd; start = 1'b1;
    e.acc = e_acc; e.c = e_c; e.v = e_v;
    exp_q.push_back(e);
    acc0 = acc;
    n_busy = 0; lat = 0; seen = 0; held = 1;
    for (int k = 0; k < int'(W) + 4 && !seen; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        operand = 8'($urandom);
        op = 2'($urandom);
      end
      lat++;
      if (busy) begin
        n_busy++;
        if (acc !== acc0) held = 0;
      end
      if (done) seen = 1;
    end
    check("done_seen", 64'(seen), 64'(1));
    check("done_latency", 64'(lat), serial ? 64'(W + 1) : 64'(1));
    check("busy_cycles", 64'(n_busy), serial ? 64'(W) : 64'(0));
    check("acc_held_during_calc", 64'(held), 64'(1));
    if (!seen && exp_q.size() > 0) void'(exp_q.pop_back());
  endtask

  // Parallel operation on the 4- and 12-bit DUTs
  task automatic small_op(input logic [1:0] op_v, input logic [3:0] o4, input logic [11:0] o12,
                          output int b4, output int b12, output int l4, output int l12);
    b4 = 0; b12 = 0; l4 = 0; l12 = 0;
    @(negedge clk);
    op_s = op_v; opnd4 = o4; opnd12 = o12; start_s = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (busy4) b4++;
      if (busy12) b12++;
      if (done4 && l4 == 0) l4 = k;
      if (done12 && l12 == 0) l12 = k;
    end
  endtask

  vec_t vecs[14];

  initial begin
    int dc0, b4, b12, l4, l12;
    bit busy_seen;

    vecs[0]  = '{2'b10, 8'h7F, 8'h7F, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[2]  = '{2'b00, 8'hFF, 8'h7F, 1'b1, 1'b1};
    vecs[3]  = '{2'b10, 8'h05, 8'h05, 1'b0, 1'b0};
    vecs[4]  = '{2'b01, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[5]  = '{2'b01, 8'hFE, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{2'b11, 8'h99, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 8'h3C, 8'h3C, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 8'h50, 8'hEC, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 8'h7F, 8'h6B, 1'b1, 1'b0};
    vecs[10] = '{2'b10, 8'h40, 8'h40, 1'b0, 1'b0};
    vecs[11] = '{2'b00, 8'h40, 8'h80, 1'b0, 1'b1};
    vecs[12] = '{2'b01, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[13] = '{2'b10, 8'hA5, 8'hA5, 1'b0, 1'b0};

    // Reset with start held high
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_acc", 64'(acc), 64'(0));
    check("rst_flags", 64'({carry, ovf, busy, done}), 64'(0));
    rst = 1'b0;
    dc0 = done_cnt;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    check("no_done_start_held", 64'(done_cnt - dc0), 64'(0));
    check("no_busy_start_held", 64'(busy_seen), 64'(0));
    check("rst_hex", 64'(hex), 64'({seg7(4'h0), seg7(4'h0), seg7(4'h0)}));
    start = 1'b0;
    @(negedge clk);

    // Table-driven sequence
    for (int i = 0; i < 14; i++)
      do_op(vecs[i].op, vecs[i].opnd, vecs[i].acc, vecs[i].c, vecs[i].v);

    // Start pulses during CALC are dropped; operand changes ignored
    do_op(2'b10, 8'h10, 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    op = 2'b00; operand = 8'h22; start = 1'b1;
    begin
      exp_t e;
      e.acc = 8'h32; e.c = 1'b0; e.v = 1'b0;
      exp_q.push_back(e);
    end
    dc0 = done_cnt;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = (k == 2 || k == 5);
      operand = 8'($urandom);
      op = 2'($urandom);
    end
    start = 1'b0;
    check("single_done_with_extra_starts", 64'(done_cnt - dc0), 64'(1));

    // Reset in CALC cycle 4 aborts the ADD
    do_op(2'b10, 8'h11, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    op = 2'b00; operand = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_acc", 64'(acc), 64'(0));
    check("abort_busy_done", 64'({busy, done}), 64'(0));
    rst = 1'b0;
    dc0 = done_cnt;
    repeat (12) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dc0), 64'(0));

    // LOAD/ADD on WIDTH=4 and WIDTH=12
    small_op(2'b10, 4'h7, 12'h7FF, b4, b12, l4, l12);
    check("w4_load_acc", 64'(acc4), 64'(4'h7));
    check("w12_load_acc", 64'(acc12), 64'(12'h7FF));
    check("w4_load_latency", 64'(l4), 64'(1));
    small_op(2'b00, 4'h1, 12'h001, b4, b12, l4, l12);
    check("w4_busy_cycles", 64'(b4), 64'(4));
    check("w12_busy_cycles", 64'(b12), 64'(12));
    check("w4_done_latency", 64'(l4), 64'(5));
    check("w12_done_latency", 64'(l12), 64'(13));
    check("w4_result", 64'({acc4, c4, v4}), 64'({4'h8, 1'b0, 1'b1}));
    check("w12_result", 64'({acc12, c12, v12}), 64'({12'h800, 1'b0, 1'b1}));
    check("w4_hex", 64'(hex4), 64'({seg7(4'h0), seg7(4'h8)}));

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_accumulator_calculator.md
Name: serial_accumulator_calculator

Overview:
- Clocked, parametrised successor of the 4-bit combinational adder/display calculator.
- Holds a WIDTH-bit accumulator and applies ADD, SUB, LOAD or CLEAR with an operand taken from the switches.
- ADD/SUB run bit-serially through one full-adder slice, one bit per clock.
- The accumulator and the carry flag drive a bank of seven-segment displays through decoder_de10_lite instances.

Parameters:
- WIDTH, 8, operand/accumulator width in bits; must be a multiple of 4 and at least 4.
- N_DIGITS, WIDTH/4, number of result hex digits; derived, not overridable.

Ports:
- i_clk  input  1  system clock; single clock domain.
- i_reset  input  1  synchronous, active-high reset.
- i_operand  input  WIDTH  operand B, sampled only when a start is accepted.
- i_op  input  2  operation: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR; sampled only at accept.
- i_start  input  1  level request, e.g. from a button; the block acts on its rising edge.
- o_acc  output  WIDTH  accumulator value.
- o_carry  output  1  carry out of the last ADD/SUB; for SUB, 1 = no borrow.
- o_overflow  output  1  two's-complement overflow of the last ADD/SUB.
- o_busy  output  1  serial operation in progress.
- o_done  output  1  one-cycle pulse when an operation completes.
- o_hex  output  7*(N_DIGITS+1)  active-low segments; digit k occupies bits [7k+6:7k]. Digits 0..N_DIGITS-1 show o_acc nibbles, LSB nibble first. Top digit shows o_carry as 0 or 1.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset.
- Reset values: o_acc=0, o_carry=0, o_overflow=0, o_busy=0, o_done=0, state IDLE. The start-history register resets to 1, so an i_start held high across reset does not trigger an operation.
- Edge detect: start_edge = i_start & ~start_q, where start_q is the registered i_start. Accept = start_edge in state IDLE. A start_edge in state CALC is dropped; nothing is queued.
- States: IDLE and CALC.
- LOAD accepted at edge t0: o_acc <= i_operand, flags cleared. o_done=1 for the single cycle after t0. o_busy stays 0.
- CLEAR accepted at edge t0: o_acc <= 0, flags cleared. Same o_done timing as LOAD.
- ADD/SUB accepted at edge t0:
  - Copy o_acc into shift register A.
  - Load shift register B with i_operand (ADD) or ~i_operand (SUB).
  - Carry register <= i_op[0]; bit counter <= 0; go to CALC.
  - o_busy=1 from the cycle after t0 for exactly WIDTH cycles.
- CALC, each edge:
  - s = A[0]^B[0]^c; c <= majority(A[0], B[0], c).
  - Shift A and B right; shift s into the MSB of the result shift register; increment the counter.
- Completion, on the WIDTH-th CALC edge (t0+WIDTH):
  - o_acc <= result; o_carry <= final carry.
  - o_overflow <= (A_msb == B_msb) & (sum_msb != A_msb), where A_msb and B_msb are the MSBs of the original operands.
  - Return to IDLE. o_done=1 for the cycle after t0+WIDTH; o_busy=0 in that same cycle.
- Hold rules: o_acc and the flags are unchanged during CALC. i_operand and i_op changes during CALC have no effect.
- Arithmetic: all results wrap modulo 2^WIDTH.
- Reset mid-CALC: abort immediately to reset values. No o_done pulse; partial result discarded.
- Back-to-back: a new start is accepted at the earliest in the o_done cycle, provided its rising edge falls there.
- Display: o_hex is purely combinational from o_acc and o_carry, using decoder_de10_lite segment mapping.

Test Plan:
- Reset with i_start held high, WIDTH=8 -> o_acc=0x00, o_hex shows "000", no o_done for 20 cycles after reset release while i_start stays high.
- LOAD 0x7F, then ADD 0x01 -> o_busy high exactly 8 cycles, o_done in the 9th cycle after accept, o_acc=0x80, o_carry=0, o_overflow=1.
- acc=0x80, ADD 0xFF -> o_acc=0x7F, o_carry=1, o_overflow=1; top hex digit shows "1".
- acc=0x05, SUB 0x07 -> o_acc=0xFE, o_carry=0, o_overflow=0. Then SUB 0xFE -> o_acc=0x00, o_carry=1.
- Start pulses at CALC cycles 2 and 5, and i_operand toggled during CALC -> exactly one o_done; result uses only the operand sampled at accept.
- i_reset asserted in CALC cycle 4 of ADD -> next cycle o_acc=0, o_busy=0, no o_done. Repeat the LOAD/ADD scenario with WIDTH=4 and WIDTH=12; busy length equals WIDTH.
